// File: rtl/stopwatch_display_pkg.sv
// Shared types and constants for the stopwatch BCD converter and 7-segment multiplexer.
package stopwatch_display_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CONV_SEC = 2'd1,
        CONV_MIN = 2'd2,
        COMMIT   = 2'd3
    } state_e;

    // Active-high patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [1:0] DIG_SEC_ONES = 2'd0;
    localparam logic [1:0] DIG_SEC_TENS = 2'd1;
    localparam logic [1:0] DIG_MIN_ONES = 2'd2;
    localparam logic [1:0] DIG_MIN_TENS = 2'd3;

    localparam int REFRESH_DIV_DEF = 50000;

endpackage

// File: rtl/stopwatch_display_if.sv
// Stopwatch-to-display bus: binary time in, pin drive and committed BCD out.
interface stopwatch_display_if;
    logic [5:0]  sec;
    logic [5:0]  min;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [15:0] bcd;
    logic        conv_done;

    modport master (output sec, output min,
                    input seg, input dp, input an, input bcd, input conv_done);
    modport slave  (input sec, input min,
                    output seg, output dp, output an, output bcd, output conv_done);
endinterface

// File: rtl/stopwatch_display_seg7_decoder.sv
// Combinational BCD digit to active-high 7-segment pattern; codes above 9 blank.
module seg7_decoder
    import stopwatch_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] pattern
);

    // Digit lookup
    always_comb begin
        pattern = SEG_BLANK;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/stopwatch_display.sv
// Binary MM:SS to BCD via iterative subtract-10 FSM, then multiplexed onto a 4-digit 7-segment display.
module stopwatch_display
    import stopwatch_display_pkg::*;
#(
    parameter int REFRESH_DIV    = REFRESH_DIV_DEF,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
)(
    input  logic                clk,
    input  logic                rst_n,
    stopwatch_display_if.slave  bus
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    state_e      state_r;
    logic [5:0]  snap_sec_r, snap_min_r, comm_sec_r, comm_min_r, rem_r;
    logic [2:0]  tens_r, sec_tens_r, min_tens_r;
    logic [3:0]  sec_ones_r, min_ones_r;
    logic [15:0] bcd_r;
    logic        conv_done_r;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]  idx_r;
    logic [6:0]  seg_r;
    logic        dp_r;
    logic [3:0]  an_r;
    logic [3:0]  digit_s;
    logic [6:0]  pattern_s;

    // Conversion FSM; the remainder register is reused for seconds then minutes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            snap_sec_r  <= 6'd0;
            snap_min_r  <= 6'd0;
            comm_sec_r  <= 6'd0;
            comm_min_r  <= 6'd0;
            rem_r       <= 6'd0;
            tens_r      <= 3'd0;
            sec_tens_r  <= 3'd0;
            min_tens_r  <= 3'd0;
            sec_ones_r  <= 4'd0;
            min_ones_r  <= 4'd0;
            bcd_r       <= 16'd0;
            conv_done_r <= 1'b0;
        end else begin
            conv_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if ({bus.min, bus.sec} != {comm_min_r, comm_sec_r}) begin
                        snap_sec_r <= bus.sec;
                        snap_min_r <= bus.min;
                        rem_r      <= bus.sec;
                        tens_r     <= 3'd0;
                        state_r    <= CONV_SEC;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                CONV_SEC: begin
                    if (rem_r >= 6'd10) begin
                        rem_r  <= rem_r - 6'd10;
                        tens_r <= tens_r + 3'd1;
                    end else begin
                        sec_ones_r <= rem_r[3:0];
                        sec_tens_r <= tens_r;
                        rem_r      <= snap_min_r;
                        tens_r     <= 3'd0;
                        state_r    <= CONV_MIN;
                    end
                end
                CONV_MIN: begin
                    if (rem_r >= 6'd10) begin
                        rem_r  <= rem_r - 6'd10;
                        tens_r <= tens_r + 3'd1;
                    end else begin
                        min_ones_r <= rem_r[3:0];
                        min_tens_r <= tens_r;
                        state_r    <= COMMIT;
                    end
                end
                COMMIT: begin
                    bcd_r       <= {1'b0, min_tens_r, min_ones_r, 1'b0, sec_tens_r, sec_ones_r};
                    comm_sec_r  <= snap_sec_r;
                    comm_min_r  <= snap_min_r;
                    conv_done_r <= 1'b1;
                    state_r     <= IDLE;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Digit slot timer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= '0;
            idx_r <= 2'd0;
        end else if (cnt_r == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_r <= '0;
            idx_r <= idx_r + 2'd1;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Select the committed digit for the current slot
    always_comb begin
        digit_s = 4'd0;
        case (idx_r)
            DIG_SEC_ONES: digit_s = bcd_r[3:0];
            DIG_SEC_TENS: digit_s = bcd_r[7:4];
            DIG_MIN_ONES: digit_s = bcd_r[11:8];
            DIG_MIN_TENS: digit_s = bcd_r[15:12];
            default:      digit_s = 4'd0;
        endcase
    end

    seg7_decoder u_dec (
        .digit   (digit_s),
        .pattern (pattern_s)
    );

    // Pin registers with polarity applied
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_r <= SEG_0 ^ {7{SEG_ACTIVE_LOW}};
            an_r  <= 4'b0001 ^ {4{AN_ACTIVE_LOW}};
            dp_r  <= SEG_ACTIVE_LOW;
        end else begin
            seg_r <= pattern_s ^ {7{SEG_ACTIVE_LOW}};
            an_r  <= (4'b0001 << idx_r) ^ {4{AN_ACTIVE_LOW}};
            dp_r  <= (idx_r == DIG_MIN_ONES) ^ SEG_ACTIVE_LOW;
        end
    end

    assign bus.seg       = seg_r;
    assign bus.an        = an_r;
    assign bus.dp        = dp_r;
    assign bus.bcd       = bcd_r;
    assign bus.conv_done = conv_done_r;

endmodule

// File: tb/tb_stopwatch_display.sv
// Directed self-checking bench for stopwatch_display with a 4-cycle digit slot.
module tb_stopwatch_display;
    import stopwatch_display_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    stopwatch_display_if bus ();

    stopwatch_display #(
        .REFRESH_DIV    (4),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Edges counted after the sampling edge until conv_done is seen; -1 on timeout
    task automatic wait_done(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (bus.conv_done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_an;
        int slot;
        int seen_done;
        bus.sec = 6'd0;
        bus.min = 6'd0;
        rst_n   = 1'b0;
        step();
        step();
        checks++;
        if (bus.an !== 4'b1110 || bus.seg !== 7'h40 || bus.dp !== 1'b1 || bus.bcd !== 16'h0000 || bus.conv_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got an=%b seg=%h dp=%b bcd=%h done=%b want an=1110 seg=40 dp=1 bcd=0000 done=0",
                     bus.an, bus.seg, bus.dp, bus.bcd, bus.conv_done);
        end
        rst_n = 1'b1;
        seen_done = 0;
        for (int n = 1; n <= 16; n++) begin
            step();
            slot   = ((n - 1) / 4) % 4;
            exp_an = ~(4'b0001 << slot);
            if (bus.conv_done === 1'b1) seen_done = 1;
            checks++;
            if (bus.an !== exp_an) begin
                errors++;
                $display("FAIL scan_an cycle %0d got %b want %b", n, bus.an, exp_an);
            end
            checks++;
            if (bus.seg !== 7'h40) begin
                errors++;
                $display("FAIL scan_seg cycle %0d got %h want 40", n, bus.seg);
            end
            checks++;
            if (bus.dp !== (slot != 2)) begin
                errors++;
                $display("FAIL scan_dp cycle %0d got %b want %b", n, bus.dp, (slot != 2));
            end
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL idle_no_done got pulse want none");
        end
    endtask

    task automatic test_max_latency();
        int n;
        bus.sec = 6'd59;
        bus.min = 6'd59;
        step();
        wait_done(40, n);
        checks++;
        if (n != 13) begin
            errors++;
            $display("FAIL latency_5959 got %0d want 13", n);
        end
        checks++;
        if (bus.bcd !== 16'h5959) begin
            errors++;
            $display("FAIL bcd_5959 got %h want 5959", bus.bcd);
        end
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (bus.an === 4'b1110) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n < 0 || bus.seg !== 7'h10) begin
            errors++;
            $display("FAIL slot0_nine got seg=%h an=%b want seg=10 an=1110", bus.seg, bus.an);
        end
    endtask

    task automatic test_small();
        int n;
        bus.sec = 6'd7;
        bus.min = 6'd0;
        step();
        wait_done(40, n);
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL latency_0007 got %0d want 3", n);
        end
        checks++;
        if (bus.bcd !== 16'h0007) begin
            errors++;
            $display("FAIL bcd_0007 got %h want 0007", bus.bcd);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bus.sec = 6'd12;
        bus.min = 6'd0;
        step();
        bus.sec = 6'd13;
        wait_done(40, n);
        checks++;
        if (n != 4 || bus.bcd !== 16'h0012) begin
            errors++;
            $display("FAIL first_commit got n=%0d bcd=%h want n=4 bcd=0012", n, bus.bcd);
        end
        wait_done(40, n);
        checks++;
        if (n < 0 || bus.bcd !== 16'h0013) begin
            errors++;
            $display("FAIL second_commit got n=%0d bcd=%h want bcd=0013", n, bus.bcd);
        end
    endtask

    task automatic test_out_of_range();
        int n;
        bus.sec = 6'd63;
        bus.min = 6'd60;
        step();
        wait_done(40, n);
        checks++;
        if (n != 15 || bus.bcd !== 16'h6063) begin
            errors++;
            $display("FAIL bcd_6063 got n=%0d bcd=%h want n=15 bcd=6063", n, bus.bcd);
        end
        step();
        checks++;
        if (dut.state_r !== IDLE || bus.conv_done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_6063 got state=%0d done=%b want state=0 done=0", dut.state_r, bus.conv_done);
        end
    endtask

    task automatic test_reset_mid_conv();
        int seen_done;
        bus.sec = 6'd5;
        bus.min = 6'd59;
        step();
        step();
        checks++;
        if (dut.state_r !== CONV_MIN) begin
            errors++;
            $display("FAIL reach_conv_min got state=%0d want 2", dut.state_r);
        end
        rst_n   = 1'b0;
        bus.sec = 6'd0;
        bus.min = 6'd0;
        step();
        checks++;
        if (dut.state_r !== IDLE || bus.bcd !== 16'h0000 || bus.seg !== 7'h40 || bus.an !== 4'b1110 || bus.conv_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset got state=%0d bcd=%h seg=%h an=%b done=%b want 0 0000 40 1110 0",
                     dut.state_r, bus.bcd, bus.seg, bus.an, bus.conv_done);
        end
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.conv_done === 1'b1) seen_done = 1;
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL aborted_done got pulse want none");
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        bus.sec = 6'd0;
        bus.min = 6'd0;
        test_reset();
        test_max_latency();
        test_small();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_conv();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
